mips_pipe_ctrl: RTL and testbench
=================================

Name: mips_pipe_ctrl

Overview:
- Central pipeline-control block for the MIPS core. Successor to the fixed 5-stage top-level wiring, which had only combinational stall/flush.
- Replaces ad-hoc stall/flush with per-stage `stall`/`flush` vectors, parametrised in stage count and bus width.
- Owns the req/addr_ok/data_ok handshakes for the instruction and data buses. Holds a 1-entry fetch buffer and tracks stale in-flight fetches.
- Sits beside the controller and datapath under `mips`. The datapath gates its pipeline registers with `stall[k]` and `flush[k]`.

Parameters:
- `NSTAGE`, 5, number of pipeline stages. Index 0=F, 1=D, 2=E, 3=M, 4..NSTAGE-1 = writeback side. Must be ≥5.
- `DATA_W`, 32, instruction bus data width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst_req` out 1: instruction bus request.
- `inst_addr_ok` in 1: instruction address accepted.
- `inst_data_ok` in 1: instruction data returned.
- `inst_rdata` in DATA_W: returned instruction.
- `instrF` out DATA_W: buffered instruction for the F→D register.
- `instr_validF` out 1: `instrF` is valid.
- `data_reqM` in 1: M stage holds a load/store.
- `data_req` out 1: data bus request.
- `data_addr_ok` in 1: data address accepted.
- `data_data_ok` in 1: data transfer complete.
- `lwstallD` in 1: load-use hazard in D.
- `div_busyE` in 1: multi-cycle mul/div occupying E.
- `redirectD` in 1: taken branch/jump whose delay slot is already in D. Pulse.
- `except_flush` in 1: exception/eret; flush all stages. Pulse.
- `stall` out NSTAGE: per-stage hold.
- `flush` out NSTAGE: per-stage bubble insert.

Behaviour:
- Reset (`rst`=0, async): both FSMs IDLE; `ibuf_valid`=0; discard=0; `inst_req`=0; `data_req`=0; `instrF`=0; `instr_validF`=0; `stall`=0; `flush`=0.

Fetch FSM (IF_IDLE, IF_WAIT_ADDR, IF_WAIT_DATA):
- IF_IDLE → IF_WAIT_ADDR when `ibuf_valid`=0, or `ibuf_valid`=1 and `stall[0]`=0 (the buffer drains this cycle).
- `inst_req`=1 exactly in IF_WAIT_ADDR. Hold it until `inst_addr_ok`, then → IF_WAIT_DATA.
- IF_WAIT_DATA → IF_IDLE on `inst_data_ok`. Capture `inst_rdata` into `ibuf` and set `ibuf_valid`, unless discard=1; if discard=1, drop the data and clear discard.
- `inst_addr_ok` and `inst_data_ok` in the same cycle are legal only in IF_WAIT_DATA. The same-cycle data belongs to the earlier request. At most 1 outstanding fetch.
- `redirectD` or `except_flush`: set discard if the FSM is in IF_WAIT_DATA, and clear `ibuf_valid`.
- `instrF`=`ibuf`, `instr_validF`=`ibuf_valid`. The F→D transfer occurs when `ibuf_valid` & ~`stall[0]`, which clears `ibuf_valid`. A simultaneous refill wins.

Data FSM (DM_IDLE, DM_WAIT_ADDR, DM_WAIT_DATA, DM_DONE):
- DM_IDLE → DM_WAIT_ADDR when `data_reqM`=1.
- `data_req`=1 exactly in DM_WAIT_ADDR. On `data_addr_ok` → DM_WAIT_DATA.
- DM_WAIT_DATA → DM_DONE on `data_data_ok`.
- DM_DONE → DM_IDLE when `stall[3]`=0.
- `except_flush` while in DM_WAIT_DATA does not cancel; the transaction runs to `data_data_ok`.

Stall sources (highest index wins):
- `mem_stall` = `data_reqM` & state≠DM_DONE → stall stages 0..3.
- `div_busyE` → stages 0..2.
- `lwstallD` → 0..1.
- `fetch_stall` = ~`ibuf_valid` → stage 0 only.
- `stall` is always a contiguous low-order prefix. Stages ≥4 never stall.

Flush:
- `flush[k+1]` = `stall[k]` & ~`stall[k+1]` (bubble into the first advancing stage).
- `except_flush` forces `flush` = all-ones and overrides all other flush terms. Stall still applies to stage 3 if `mem_stall`.
- `redirectD` has no effect on `stall`/`flush`.
- Outputs `stall`/`flush` are combinational from FSM state plus inputs. No latency beyond that.

Decomposition:
- Package `mips_pkg`: stage-index constants (STG_F, STG_D, STG_E, STG_M), fetch/data FSM state encodings.
- Sub-module `bus_hs_fsm` (one req/addr_ok/data_ok channel with a hold-until-release state), instantiated twice: fetch instance release = F advance, data instance release = ~`stall[3]`. Prefix/flush logic stays in the top module.

Test Plan:
- Fetch, 0-wait bus: `addr_ok` cycle 1, `data_ok` cycle 2, `inst_rdata`=0x24020005 → `instr_validF`=1 cycle 3; `stall`=0 after; `stall[0]`=1 cycles 0-2.
- Load with `data_ok` 3 cycles after `addr_ok` → `stall`=5'b01111, `flush`=5'b10000 each wait cycle; DM_DONE then IDLE once `stall[3]` drops.
- `lwstallD`=1 with `div_busyE`=1 → `stall`=5'b00111, `flush[3]`=1. Drop `div_busyE` → `stall`=5'b00011, `flush[2]`=1.
- `redirectD` during IF_WAIT_DATA → returned word 0xDEADBEEF dropped (`instr_validF` stays 0); next request issued; following word accepted.
- `except_flush` mid-load → `flush`=5'b11111 that cycle; `stall[3]` held until `data_data_ok`; no spurious second `data_req`.
- Async reset asserted mid-IF_WAIT_DATA → all outputs 0 immediately. A `data_ok` arriving after `rst` release is ignored (FSM IDLE).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline-control slice: stage indices and
// handshake FSM state encodings. The fetch and data encodings use the same
// values as the generic channel FSM, so a channel state can be cast to either.
package mips_pkg;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;

    typedef enum logic [1:0] {
        HS_IDLE      = 2'd0,
        HS_WAIT_ADDR = 2'd1,
        HS_WAIT_DATA = 2'd2,
        HS_DONE      = 2'd3
    } hs_state_e;

    typedef enum logic [1:0] {
        IF_IDLE      = 2'd0,
        IF_WAIT_ADDR = 2'd1,
        IF_WAIT_DATA = 2'd2
    } if_state_e;

    typedef enum logic [1:0] {
        DM_IDLE      = 2'd0,
        DM_WAIT_ADDR = 2'd1,
        DM_WAIT_DATA = 2'd2,
        DM_DONE      = 2'd3
    } dm_state_e;

endpackage

// File: rtl/bus_hs_fsm.sv
// One req/addr_ok/data_ok bus channel. The request is raised only while
// waiting for address acceptance; at most one transfer is outstanding.
// With HOLD set, a completed transfer parks in HS_DONE until release_i.
module bus_hs_fsm
    import mips_pkg::*;
#(
    parameter logic HOLD = 1'b1
)
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start_i,
    input  logic      release_i,
    input  logic      addr_ok_i,
    input  logic      data_ok_i,
    output logic      req_o,
    output hs_state_e state_o
);

    hs_state_e state_q;
    hs_state_e state_d;

    // State register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start, wait for address accept, wait for data, optional hold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HS_IDLE: begin
                if (start_i) begin
                    state_d = HS_WAIT_ADDR;
                end
            end
            HS_WAIT_ADDR: begin
                if (addr_ok_i) begin
                    state_d = HS_WAIT_DATA;
                end
            end
            HS_WAIT_DATA: begin
                if (data_ok_i) begin
                    if (HOLD) begin
                        state_d = HS_DONE;
                    end else begin
                        state_d = HS_IDLE;
                    end
                end
            end
            HS_DONE: begin
                if (release_i) begin
                    state_d = HS_IDLE;
                end
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    assign req_o   = (state_q == HS_WAIT_ADDR);
    assign state_o = state_q;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline control for the MIPS core: instruction/data bus handshakes,
// a one-entry fetch buffer with stale-fetch discard, and per-stage
// stall/flush vectors. Stall is always a contiguous low-order prefix;
// the first stage that advances past a stalled one receives a bubble.
module mips_pipe_ctrl
    import mips_pkg::*;
#(
    parameter int NSTAGE = 5,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    output logic              inst_req,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic [DATA_W-1:0] instrF,
    output logic              instr_validF,
    input  logic              data_reqM,
    output logic              data_req,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic              lwstallD,
    input  logic              div_busyE,
    input  logic              redirectD,
    input  logic              except_flush,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush
);

    hs_state_e         fetchHs;
    hs_state_e         dataHs;
    if_state_e         ifState;
    dm_state_e         dmState;

    logic [DATA_W-1:0] ibuf_q;
    logic [DATA_W-1:0] ibuf_d;
    logic              ibufValid_q;
    logic              ibufValid_d;
    logic              discard_q;
    logic              discard_d;

    logic              memStall;
    logic              fetchStall;
    logic              fAdvance;
    logic              fetchStart;
    logic              fetchFire;
    logic              killFetch;
    logic [NSTAGE-1:0] stallVec;
    logic [NSTAGE-1:0] flushVec;

    assign ifState = if_state_e'(fetchHs);
    assign dmState = dm_state_e'(dataHs);

    // The buffered word moves into D whenever F is not held; a new fetch may
    // start as soon as the buffer is empty or is draining this cycle.
    assign fAdvance   = ibufValid_q & ~stallVec[STG_F];
    assign fetchStart = ~ibufValid_q | fAdvance;
    assign fetchFire  = (ifState == IF_WAIT_DATA) & inst_data_ok;
    assign killFetch  = redirectD | except_flush;

    assign memStall   = data_reqM & (dmState != DM_DONE);
    assign fetchStall = ~ibufValid_q;

    bus_hs_fsm #(
        .HOLD      (1'b0)
    ) u_fetch_hs (
        .clk       (clk),
        .rst       (rst),
        .start_i   (fetchStart),
        .release_i (fAdvance),
        .addr_ok_i (inst_addr_ok),
        .data_ok_i (inst_data_ok),
        .req_o     (inst_req),
        .state_o   (fetchHs)
    );

    bus_hs_fsm #(
        .HOLD      (1'b1)
    ) u_data_hs (
        .clk       (clk),
        .rst       (rst),
        .start_i   (data_reqM),
        .release_i (~stallVec[STG_M]),
        .addr_ok_i (data_addr_ok),
        .data_ok_i (data_data_ok),
        .req_o     (data_req),
        .state_o   (dataHs)
    );

    // Fetch buffer and discard flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ibuf_q      <= '0;
            ibufValid_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            ibuf_q      <= ibuf_d;
            ibufValid_q <= ibufValid_d;
            discard_q   <= discard_d;
        end
    end

    // Buffer update: drain on F advance or redirect, mark an in-flight fetch
    // stale on redirect, and let a fresh returning word win over the drain.
    always_comb begin
        ibuf_d      = ibuf_q;
        ibufValid_d = ibufValid_q;
        discard_d   = discard_q;
        if (fAdvance || killFetch) begin
            ibufValid_d = 1'b0;
        end
        if (killFetch && (ifState == IF_WAIT_DATA) && !inst_data_ok) begin
            discard_d = 1'b1;
        end
        if (fetchFire) begin
            if (discard_q) begin
                discard_d = 1'b0;
            end else if (!killFetch) begin
                ibuf_d      = inst_rdata;
                ibufValid_d = 1'b1;
            end
        end
    end

    // Stall prefix: each source holds every stage up to and including its own.
    always_comb begin
        stallVec = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if ((k <= STG_M) && memStall) begin
                stallVec[k] = 1'b1;
            end
            if ((k <= STG_E) && div_busyE) begin
                stallVec[k] = 1'b1;
            end
            if ((k <= STG_D) && lwstallD) begin
                stallVec[k] = 1'b1;
            end
            if ((k == STG_F) && fetchStall) begin
                stallVec[k] = 1'b1;
            end
        end
    end

    // Bubble into the first stage that advances behind a held one; an
    // exception flushes every stage regardless.
    always_comb begin
        flushVec = '0;
        for (int k = 0; k < NSTAGE - 1; k++) begin
            flushVec[k+1] = stallVec[k] & ~stallVec[k+1];
        end
        if (except_flush) begin
            flushVec = '1;
        end
    end

    assign stall        = rst ? stallVec : '0;
    assign flush        = rst ? flushVec : '0;
    assign instrF       = ibuf_q;
    assign instr_validF = ibufValid_q;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl. Fetched words expected to reach D are
// queued when the bus returns them and compared when F hands them over.
module tb_mips_pipe_ctrl;

    localparam int NSTAGE = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              inst_req;
    logic              inst_addr_ok = 1'b0;
    logic              inst_data_ok = 1'b0;
    logic [DATA_W-1:0] inst_rdata = '0;
    logic [DATA_W-1:0] instrF;
    logic              instr_validF;
    logic              data_reqM = 1'b0;
    logic              data_req;
    logic              data_addr_ok = 1'b0;
    logic              data_data_ok = 1'b0;
    logic              lwstallD = 1'b0;
    logic              div_busyE = 1'b0;
    logic              redirectD = 1'b0;
    logic              except_flush = 1'b0;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] expQ[$];

    mips_pipe_ctrl #(
        .NSTAGE       (NSTAGE),
        .DATA_W       (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .instrF       (instrF),
        .instr_validF (instr_validF),
        .data_reqM    (data_reqM),
        .data_req     (data_req),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .lwstallD     (lwstallD),
        .div_busyE    (div_busyE),
        .redirectD    (redirectD),
        .except_flush (except_flush),
        .stall        (stall),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Move to just after the next rising edge and drop all one-cycle pulses.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        redirectD    = 1'b0;
        except_flush = 1'b0;
    endtask

    // Sample on the falling edge; pop the scoreboard on an F->D transfer.
    task automatic sampleCycle();
        logic [31:0] e;
        @(negedge clk);
        if (instr_validF && !stall[0]) begin
            nCompared++;
            assert (expQ.size() > 0) else begin
                nMismatched++;
                $error("[TB] FAIL sb_unexpected observed=0x%08h expected=none", instrF);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_instrF", instrF, e);
            end
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_inst_req"}, 32'(inst_req), 32'h0);
        checkOutput({tag, "_data_req"}, 32'(data_req), 32'h0);
        checkOutput({tag, "_instrF"}, instrF, 32'h0);
        checkOutput({tag, "_validF"}, 32'(instr_validF), 32'h0);
        checkOutput({tag, "_stall"}, 32'(stall), 32'h0);
        checkOutput({tag, "_flush"}, 32'(flush), 32'h0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("rst");

        // Fetch on a zero-wait bus.
        applyStimulus(); rst = 1'b1;
        sampleCycle();
        checkOutput("c0_inst_req", 32'(inst_req), 32'h0);
        checkOutput("c0_stall", 32'(stall), 32'h01);
        checkOutput("c0_flush", 32'(flush), 32'h02);
        applyStimulus(); inst_addr_ok = 1'b1;
        sampleCycle();
        checkOutput("c1_inst_req", 32'(inst_req), 32'h1);
        checkOutput("c1_stall", 32'(stall), 32'h01);
        applyStimulus(); inst_data_ok = 1'b1; inst_rdata = 32'h2402_0005; expQ.push_back(32'h2402_0005);
        sampleCycle();
        checkOutput("c2_inst_req", 32'(inst_req), 32'h0);
        checkOutput("c2_validF", 32'(instr_validF), 32'h0);
        checkOutput("c2_stall", 32'(stall), 32'h01);
        applyStimulus();
        sampleCycle();
        checkOutput("c3_validF", 32'(instr_validF), 32'h1);
        checkOutput("c3_stall", 32'(stall), 32'h00);
        checkOutput("c3_flush", 32'(flush), 32'h00);
        applyStimulus();
        sampleCycle();
        checkOutput("c4_inst_req", 32'(inst_req), 32'h1);
        checkOutput("c4_validF", 32'(instr_validF), 32'h0);

        // Load with data_ok three cycles after addr_ok.
        applyStimulus(); data_reqM = 1'b1;
        sampleCycle();
        checkOutput("ld_idle_data_req", 32'(data_req), 32'h0);
        checkOutput("ld_idle_stall", 32'(stall), 32'h0F);
        checkOutput("ld_idle_flush", 32'(flush), 32'h10);
        applyStimulus(); data_addr_ok = 1'b1;
        sampleCycle();
        checkOutput("ld_addr_data_req", 32'(data_req), 32'h1);
        checkOutput("ld_addr_stall", 32'(stall), 32'h0F);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(); data_data_ok = (i == 2);
            sampleCycle();
            checkOutput("ld_wait_data_req", 32'(data_req), 32'h0);
            checkOutput("ld_wait_stall", 32'(stall), 32'h0F);
            checkOutput("ld_wait_flush", 32'(flush), 32'h10);
        end
        applyStimulus();
        sampleCycle();
        checkOutput("ld_done_stall", 32'(stall), 32'h01);
        checkOutput("ld_done_flush", 32'(flush), 32'h02);
        // Back-to-back access: DONE must have returned to IDLE.
        applyStimulus();
        sampleCycle();
        checkOutput("ld2_idle_stall", 32'(stall), 32'h0F);
        checkOutput("ld2_idle_data_req", 32'(data_req), 32'h0);
        applyStimulus(); data_addr_ok = 1'b1;
        sampleCycle();
        checkOutput("ld2_addr_data_req", 32'(data_req), 32'h1);
        applyStimulus(); data_data_ok = 1'b1;
        sampleCycle();
        checkOutput("ld2_wait_stall", 32'(stall), 32'h0F);
        applyStimulus(); data_reqM = 1'b0;
        sampleCycle();
        checkOutput("ld2_done_stall", 32'(stall), 32'h01);
        applyStimulus();
        sampleCycle();
        checkOutput("ld2_idle_no_req", 32'(data_req), 32'h0);

        // Load-use plus multi-cycle divide.
        applyStimulus(); lwstallD = 1'b1; div_busyE = 1'b1;
        sampleCycle();
        checkOutput("lwdiv_stall", 32'(stall), 32'h07);
        checkOutput("lwdiv_flush", 32'(flush), 32'h08);
        applyStimulus(); div_busyE = 1'b0;
        sampleCycle();
        checkOutput("lw_stall", 32'(stall), 32'h03);
        checkOutput("lw_flush", 32'(flush), 32'h04);
        applyStimulus(); lwstallD = 1'b0;
        sampleCycle();
        checkOutput("nolw_stall", 32'(stall), 32'h01);
        checkOutput("nolw_flush", 32'(flush), 32'h02);

        // Redirect while a fetch is in flight: the returned word is stale.
        applyStimulus(); inst_addr_ok = 1'b1;
        sampleCycle();
        checkOutput("rd_inst_req", 32'(inst_req), 32'h1);
        applyStimulus(); redirectD = 1'b1;
        sampleCycle();
        checkOutput("rd_stall", 32'(stall), 32'h01);
        checkOutput("rd_flush", 32'(flush), 32'h02);
        applyStimulus(); inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        sampleCycle();
        applyStimulus();
        sampleCycle();
        checkOutput("rd_drop_validF", 32'(instr_validF), 32'h0);
        checkOutput("rd_drop_inst_req", 32'(inst_req), 32'h0);
        applyStimulus(); inst_addr_ok = 1'b1;
        sampleCycle();
        checkOutput("rd_refetch_req", 32'(inst_req), 32'h1);
        applyStimulus(); inst_data_ok = 1'b1; inst_rdata = 32'h8C43_0004; expQ.push_back(32'h8C43_0004);
        sampleCycle();
        applyStimulus(); lwstallD = 1'b1;
        sampleCycle();
        checkOutput("hold_validF", 32'(instr_validF), 32'h1);
        checkOutput("hold_instrF", instrF, 32'h8C43_0004);
        checkOutput("hold_stall", 32'(stall), 32'h03);
        applyStimulus();
        sampleCycle();
        checkOutput("hold2_validF", 32'(instr_validF), 32'h1);
        checkOutput("hold2_inst_req", 32'(inst_req), 32'h0);
        applyStimulus(); lwstallD = 1'b0;
        sampleCycle();
        checkOutput("drain_stall", 32'(stall), 32'h00);
        applyStimulus();
        sampleCycle();
        checkOutput("drain_inst_req", 32'(inst_req), 32'h1);
        checkOutput("drain_validF", 32'(instr_validF), 32'h0);

        // Exception in the middle of a load.
        applyStimulus(); data_reqM = 1'b1;
        sampleCycle();
        applyStimulus(); data_addr_ok = 1'b1;
        sampleCycle();
        checkOutput("ex_addr_data_req", 32'(data_req), 32'h1);
        applyStimulus(); except_flush = 1'b1;
        sampleCycle();
        checkOutput("ex_flush", 32'(flush), 32'h1F);
        checkOutput("ex_stall", 32'(stall), 32'h0F);
        applyStimulus();
        sampleCycle();
        checkOutput("ex_wait_stall", 32'(stall), 32'h0F);
        checkOutput("ex_wait_flush", 32'(flush), 32'h10);
        checkOutput("ex_wait_data_req", 32'(data_req), 32'h0);
        applyStimulus(); data_data_ok = 1'b1;
        sampleCycle();
        checkOutput("ex_dok_stall", 32'(stall), 32'h0F);
        applyStimulus(); data_reqM = 1'b0;
        sampleCycle();
        checkOutput("ex_done_stall", 32'(stall), 32'h01);
        checkOutput("ex_done_data_req", 32'(data_req), 32'h0);
        applyStimulus();
        sampleCycle();
        checkOutput("ex_after_data_req", 32'(data_req), 32'h0);

        // Asynchronous reset while a fetch waits for data.
        applyStimulus(); inst_addr_ok = 1'b1;
        sampleCycle();
        applyStimulus();
        #2; rst = 1'b0;
        #1;
        checkIdle("arst");
        applyStimulus(); rst = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
        sampleCycle();
        checkOutput("arst_rel_validF", 32'(instr_validF), 32'h0);
        checkOutput("arst_rel_inst_req", 32'(inst_req), 32'h0);
        applyStimulus();
        sampleCycle();
        checkOutput("arst_post_validF", 32'(instr_validF), 32'h0);
        checkOutput("arst_post_instrF", instrF, 32'h0);
        checkOutput("arst_post_inst_req", 32'(inst_req), 32'h1);

        checkOutput("sb_empty", 32'(expQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
